// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data memory controller.
// Helpers work at the widest legal word (64b); callers truncate to DATA_W.
package dmem_pkg;
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} size_e;
  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_e;

  function automatic logic [MAX_W/8-1:0] be_mask(input size_e size, input logic [2:0] ofs);
    logic [MAX_W/8-1:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << ofs;
  endfunction

  // data is already shifted down to lane 0
  function automatic logic [MAX_W-1:0] ld_extend(input logic [MAX_W-1:0] data, input size_e size,
                                                 input logic uns);
    logic [MAX_W-1:0] r;
    case (size)
      SZ_B:    r = uns ? {56'b0, data[7:0]}  : {{56{data[7]}},  data[7:0]};
      SZ_H:    r = uns ? {48'b0, data[15:0]} : {{48{data[15]}}, data[15:0]};
      SZ_W:    r = uns ? {32'b0, data[31:0]} : {{32{data[31]}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/dmem_if.sv
// Load/store request and response bus between the LSU and the data memory.
interface dmem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bytemem.sv
// Byte-lane storage: one 8-bit array per lane, synchronous write, async read.
module dmem_bytemem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int NB    = DATA_W / 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NB-1:0]     be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk)
      if (we && be[b]) mem[addr] <= wdata[8*b +: 8];

    assign rdata[8*b +: 8] = mem[addr];
  end
endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: request checks, lane formatting, and read-latency FSM.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   reset_n,
  dmem_if.slave  bus
);
  localparam int NB  = DATA_W / 8;
  localparam int OFS = $clog2(NB);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e              state;
  logic [1:0]          cnt;
  logic                ready_q, rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q, hold_q;

  size_e               size;
  logic [OFS-1:0]      ofs;
  logic [ADDR_W-OFS-1:0] widx;
  logic [2:0]          a3;
  logic                misalign, oor, bad_sz, err, acc;
  logic [MAX_W/8-1:0]  be_full;
  logic [MAX_W-1:0]    ext;
  logic [DATA_W-1:0]   rword, rword_sh, wdata_sh, ld_data;
  logic                unused_ok;

  assign size = size_e'(bus.req_size);
  assign ofs  = bus.req_addr[OFS-1:0];
  assign widx = bus.req_addr[ADDR_W-1:OFS];
  assign a3   = bus.req_addr[2:0];

  always_comb begin
    misalign = 1'b0;
    case (size)
      SZ_H:    misalign = a3[0];
      SZ_W:    misalign = |a3[1:0];
      SZ_D:    misalign = |a3;
      default: misalign = 1'b0;
    endcase
  end

  assign oor    = widx >= (ADDR_W-OFS)'(DEPTH);
  assign bad_sz = (size == SZ_D) && (DATA_W == 32);
  assign err    = misalign | oor | bad_sz;
  assign acc    = bus.req_valid && ready_q;

  assign be_full  = be_mask(size, 3'(ofs));
  assign wdata_sh = bus.req_wdata << {ofs, 3'b000};

  dmem_bytemem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (acc && bus.req_we && !err),
    .be    (be_full[NB-1:0]),
    .addr  (widx[AW-1:0]),
    .wdata (wdata_sh),
    .rdata (rword)
  );

  // Load data is formatted and captured at accept, so later stores cannot disturb it.
  assign rword_sh  = rword >> {ofs, 3'b000};
  assign ext       = ld_extend(MAX_W'(rword_sh), size, bus.req_unsigned);
  assign ld_data   = ext[DATA_W-1:0];
  assign unused_ok = ^{be_full, ext};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      hold_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state)
        IDLE: if (acc) begin
          if (err) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else if (bus.req_we || RD_LAT == 1) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= bus.req_we ? '0 : ld_data;
          end else begin
            state   <= RD_WAIT;
            cnt     <= 2'(RD_LAT - 1);
            ready_q <= 1'b0;
            hold_q  <= ld_data;
          end
        end
        // Reopening on the same edge that raises rsp_valid lets the next request land as it is consumed.
        RD_WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= hold_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data memory for the MIPS core, with a request/response handshake, byte/half/word accesses with byte-lane write enables, and sign/zero-extended sub-word loads. Reads have a configurable latency, which suits multicycle and pipelined datapaths. Misaligned, out-of-range and illegal-size accesses are flagged instead of silently aliasing. The block sits between the core's load/store unit and on-chip storage.

## Interface
- `DATA_W`, default 32: word width; legal values are 32 or 64.
- `DEPTH`, default 64: number of words.
- `ADDR_W`, default 32: byte address width.
- `RD_LAT`, default 1: read latency in cycles, range 1..4.
- `clk` input, 1 bit: clock. Everything is on the rising edge.
- `reset_n` input, 1 bit: asynchronous reset, active-low.
- `req_valid` input, 1 bit: request present.
- `req_ready` output, 1 bit: block accepts a request this cycle.
- `req_we` input, 1 bit: 1 means store, 0 means load.
- `req_size` input, 2 bits: 00 byte, 01 half, 10 word, 11 doubleword (legal only when `DATA_W`=64).
- `req_unsigned` input, 1 bit: zero-extend the load result; when 0, sign-extend.
- `req_addr` input, `ADDR_W` bits: byte address.
- `req_wdata` input, `DATA_W` bits: store data, right-aligned.
- `rsp_valid` output, 1 bit: one-cycle response pulse.
- `rsp_rdata` output, `DATA_W` bits: extended load data. It is 0 for stores and for errors.
- `rsp_err` output, 1 bit: access was rejected.

## Operation
- A request is accepted on a cycle with `req_valid` && `req_ready`.
- Lane offset is `req_addr[OFS-1:0]`, where `OFS` = log2(`DATA_W`/8).
- Word index is `req_addr[ADDR_W-1:OFS]`.
- Error conditions; any one sets `rsp_err`:
  - size is not aligned: a half with `addr[0]`=1, a word with a nonzero `addr[1:0]`, or a doubleword with a nonzero `addr[2:0]`;
  - word index ≥ `DEPTH`;
  - size 11 with `DATA_W`=32;
  - on error, nothing is written and `rsp_rdata`=0.
- Store path:
  - byte-enable mask = ((1<<(1<<size))-1) << offset;
  - data = `req_wdata` << (8·offset);
  - only enabled lanes are written, at the accept edge.
- Load path:
  - the full word is read;
  - it is shifted right by 8·offset and truncated to 8<<size bits;
  - the result is then sign- or zero-extended to `DATA_W`.
- FSM states:
  - IDLE: `req_ready`=1.
    - An accepted store or an erroring access gives a response the next cycle and the block stays in IDLE.
    - An accepted valid load goes to RD_WAIT, with the counter loaded to `RD_LAT`-1.
    - When `RD_LAT`=1 the block stays in IDLE and the response comes next cycle. Back-to-back loads are then allowed.
  - RD_WAIT: `req_ready`=0. The counter decrements each cycle. At 0 the block returns to IDLE and `rsp_valid` pulses with the captured data.
- Only one load is outstanding at a time. The response port has no backpressure: the consumer always takes `rsp_valid`.
- Storage contents are not reset.
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state IDLE, counter 0.

## Timing
- Store: accept at edge N, RAM updated at edge N, `rsp_valid` high from N+1 for one cycle.
- Load: accept at edge N, `rsp_valid` from edge N+`RD_LAT` for one cycle.
- `req_ready` is low during edges N+1 … N+`RD_LAT`-1.
- An error response always has a latency of 1 cycle, whatever `RD_LAT` is.
- Read data is captured at accept, so a later store to the same word cannot change it.
- Same-address store then load on consecutive accepts: the load returns the new data.
- `reset_n` low during RD_WAIT: the pending response is dropped, outputs take their reset values immediately, and no `rsp_valid` pulse appears after release.
- `rsp_valid` is never high for two consecutive cycles unless back-to-back requests were accepted.

## Structure
- Package `dmem_pkg` holds:
  - `size_e` (SZ_B, SZ_H, SZ_W, SZ_D);
  - `state_e` (IDLE, RD_WAIT);
  - function `be_mask(size, ofs)`;
  - function `ld_extend(data, size, unsigned)`.
- Sub-module `dmem_bytemem`:
  - parameters `DATA_W`, `DEPTH`;
  - per-byte write enable, synchronous write, combinational read;
  - no reset.
- Top level holds the FSM, the latency counter, the error checks and the lane formatting.

## Test plan
- Byte store then load, `RD_LAT`=2:
  - store 0xAB to addr 0x05, then load byte signed from 0x05 → `rsp_rdata`=0xFFFFFFAB on the 2nd cycle after accept;
  - same load unsigned → 0x000000AB;
  - word 1 keeps its other bytes.
- Halfword store 0x1234 to addr 0x0A, then word load from 0x08 → 0x1234_xxxx, with bytes 0/1 unchanged.
- Misaligned word load at 0x06 → `rsp_err`=1, `rsp_rdata`=0, latency 1, memory untouched. The same applies to addr 0x100 with `DEPTH`=64 (out of range).
- Handshake with `RD_LAT`=3:
  - `req_valid` is held high across a load followed by a store;
  - `req_ready` is low for 2 cycles;
  - the store is accepted only after `rsp_valid` of the load.
- Reset mid-read: assert `reset_n`=0 one cycle after accepting a load with `RD_LAT`=4 → no `rsp_valid`, `req_ready`=1 after release, and a later load returns the stored data.
